// File: rtl/clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_prog : programmable divided clock / period strobe generator         |
// | Period and high time are reloaded only at period boundaries.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module clk_div_prog #(
    parameter int W        = 16,
    parameter int DEF_DIV  = 100,
    parameter int DEF_HIGH = 50
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    input  logic [W-1:0] cfg_high,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         o_clk,
    output logic         o_tick
);

    localparam logic [W-1:0] c_zero     = '0;
    localparam logic [W-1:0] c_one      = W'(1);
    localparam logic [W-1:0] c_two      = W'(2);
    localparam logic [W-1:0] c_def_div  = W'(DEF_DIV);
    localparam logic [W-1:0] c_def_high = W'(DEF_HIGH);

    logic [W-1:0] cnt_q,   cnt_d;
    logic [W-1:0] div_q,   div_d;
    logic [W-1:0] high_q,  high_d;
    logic [W-1:0] pdiv_q,  pdiv_d;
    logic [W-1:0] phigh_q, phigh_d;
    logic         pend_q,  pend_d;
    logic         run_q,   run_d;
    logic         oclk_q,  oclk_d;
    logic         tick_q,  tick_d;
    logic         err_q,   err_d;

    logic w_wrap;
    logic w_xfer;
    logic w_legal;
    logic w_boundary;

    always_comb begin
        w_wrap     = (cnt_q == (div_q - c_one));
        w_xfer     = cfg_valid && !pend_q;
        w_legal    = (cfg_div >= c_two) && (cfg_high != c_zero) && (cfg_high < cfg_div);
        // A new period starts here: idle, restart from idle, or end of a running period.
        w_boundary = !en || !run_q || w_wrap;

        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        run_d   = en;
        err_d   = w_xfer && !w_legal;

        if (pend_q && w_boundary) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            pend_d = 1'b0;
        end else if (w_xfer && w_legal) begin
            if (w_boundary) begin
                div_d  = cfg_div;
                high_d = cfg_high;
            end else begin
                pdiv_d  = cfg_div;
                phigh_d = cfg_high;
                pend_d  = 1'b1;
            end
        end

        cnt_d = (en && run_q && !w_wrap) ? (cnt_q + c_one) : c_zero;

        // Outputs decoded from next-state values so they are glitch-free registers.
        oclk_d = en && (cnt_d >= (div_d - high_d));
        tick_d = en && (cnt_d == c_zero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= c_zero;
            div_q   <= c_def_div;
            high_q  <= c_def_high;
            pdiv_q  <= c_def_div;
            phigh_q <= c_def_high;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            oclk_q  <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            oclk_q  <= oclk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign o_clk     = oclk_q;
    assign o_tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clk_div_prog : scoreboard bench for clk_div_prog                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_clk_div_prog;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic        cfg_ready;
    logic        cfg_err;
    logic        o_clk;
    logic        o_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic oclk;
        logic otick;
        logic rdy;
        logic err;
    } exp_t;

    exp_t sb[$];

    clk_div_prog #(
        .W        (16),
        .DEF_DIV  (100),
        .DEF_HIGH (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .o_clk     (o_clk),
        .o_tick    (o_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_row(logic c, logic t, logic r, logic e);
        sb.push_back(exp_t'({c, t, r, e}));
    endfunction

    // Expected rows for n full periods: low for div-high cycles, then high; tick on the first.
    function automatic void push_period(int div, int high, int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < div; k++)
                push_row(k >= div - high, k == 0, 1'b1, 1'b0);
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_div = 16'd10; cfg_high = 16'd3;
        repeat (30) @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        en = 1'b0;
        checks++; if (o_clk !== 1'b0)     begin errors++; $display("FAIL reset_oclk got=%b exp=0", o_clk); end
        checks++; if (o_tick !== 1'b0)    begin errors++; $display("FAIL reset_otick got=%b exp=0", o_tick); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_defaults();
        exp_t e;
        int   n;
        do_reset();
        push_period(100, 50, 10);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en = 1'b1;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL defaults cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
    endtask

    task automatic test_reconfig();
        exp_t e;
        int   n;
        do_reset();
        for (int k = 0; k < 100; k++) push_row(k >= 50, k == 0, k <= 20, 1'b0);
        push_period(10, 3, 2);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = 1'b1;
            cfg_valid = (j == 21) || (j == 51);
            cfg_div   = (j == 51) ? 16'd6 : 16'd10;
            cfg_high  = (j == 51) ? 16'd1 : 16'd3;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL reconfig cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_wrap_cfg();
        exp_t e;
        int   n;
        do_reset();
        push_period(100, 50, 1);
        push_period(4, 2, 2);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = 1'b1;
            cfg_valid = (j == 100);
            cfg_div   = 16'd4;
            cfg_high  = 16'd2;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL wrap_cfg cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e;
        int   n;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 100; k++)
                push_row(k >= 50, k == 0, 1'b1, (p == 0) && (k == 11 || k == 31 || k == 51));
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = 1'b1;
            cfg_valid = (j == 11) || (j == 31) || (j == 51);
            cfg_div   = (j == 11) ? 16'd1 : (j == 31) ? 16'd10 : 16'd8;
            cfg_high  = (j == 11) ? 16'd0 : (j == 31) ? 16'd0  : 16'd8;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL illegal cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_idle();
        exp_t e;
        int   n;
        do_reset();
        for (int k = 0; k < 31; k++) push_row(k >= 50, k == 0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++)  push_row(1'b0, 1'b0, 1'b1, 1'b0);
        push_period(6, 1, 3);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = !((j >= 31) && (j < 40));
            cfg_valid = (j == 35);
            cfg_div   = 16'd6;
            cfg_high  = 16'd1;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_pending();
        exp_t e;
        int   n;
        do_reset();
        for (int k = 0; k < 61; k++) push_row(k >= 50, k == 0, k <= 20, 1'b0);
        push_row(1'b0, 1'b0, 1'b1, 1'b0);
        push_period(100, 50, 1);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = 1'b1;
            reset     = (j == 61);
            cfg_valid = (j == 21);
            cfg_div   = 16'd10;
            cfg_high  = 16'd3;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL reset_pending cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        reset     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        do_reset();
        push_row(1'b0, 1'b0, 1'b1, 1'b0);
        push_period(2, 1, 5);
        push_period(5, 2, 3);
        n = sb.size();
        for (int j = 0; j < n; j++) begin
            en        = (j >= 1);
            cfg_valid = (j == 0) || (j == 11);
            cfg_div   = (j == 0) ? 16'd2 : 16'd5;
            cfg_high  = (j == 0) ? 16'd1 : 16'd2;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_clk, o_tick, cfg_ready, cfg_err} !== e) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", j, {o_clk, o_tick, cfg_ready, cfg_err}, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        cfg_high  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_defaults();
        test_reconfig();
        test_wrap_cfg();
        test_illegal();
        test_idle();
        test_reset_pending();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock/tick generator deriving a low-rate square wave and a one-cycle period strobe from the 100 MHz system clock. It is the generalised successor to the fixed 100:1 divider. It adds a parametrised counter width, a programmable period and high time loaded through a valid/ready handshake, glitch-free updates only at period boundaries, an enable, and illegal-configuration rejection. It sits beside the system clock input and feeds slow-rate logic (sampling, display scan, serial bit timing) as a clock-enable source.

## Interface
- W, 16, counter/config width; legal periods are 2..2^W-1
- DEF_DIV, 100, period in clk cycles after reset (1 MHz from 100 MHz)
- DEF_HIGH, 50, high-phase length in clk cycles after reset; 1 <= DEF_HIGH < DEF_DIV
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- en  in  1  run enable; low holds the generator idle
- cfg_valid  in  1  new configuration offered
- cfg_div  in  W  requested period
- cfg_high  in  W  requested high time
- cfg_ready  out  1  block can accept a configuration
- cfg_err  out  1  one-cycle pulse: offered configuration was rejected
- o_clk  out  1  registered divided clock: low phase first, then high phase
- o_tick  out  1  one-cycle strobe in the first cycle of each period

## Operation
- Active registers div_act and high_act. Counter cnt runs 0..div_act-1 and wraps to 0.
- o_clk = 1 exactly in cycles where cnt >= div_act - high_act; otherwise 0. Driven from a register (next-state decode), so there are no combinational glitches.
- o_tick = 1 exactly in cycles where cnt == 0 and en was high at the preceding edge.
- en low at an edge: next cycle cnt=0, o_clk=0, o_tick=0, counter frozen.
- en high after idle: the first cycle has cnt=0 and o_tick=1.
- Handshake: a transfer occurs at an edge with cfg_valid & cfg_ready.
- Legality check on transfer: cfg_div >= 2, cfg_high >= 1, cfg_high < cfg_div.
- Illegal config: discarded. cfg_err=1 for the next cycle only. cfg_ready stays 1. Active settings are unchanged.
- Legal config, running (en=1): values go into a pending slot and cfg_ready=0. At the next wrap edge (cnt == div_act-1), div_act/high_act load from pending, cnt=0, and cfg_ready returns to 1. The period in progress always completes with its old values.
- Legal config on the wrap edge itself: it takes effect for the period starting at that edge, with no pending stage.
- Legal config while idle (en=0): applied at that edge. cfg_ready stays 1.
- Pending config when en falls: applied at the en-low edge. cfg_ready returns to 1.
- Reset (any time, including mid-period or with a pending config):
  - cnt=0, div_act=DEF_DIV, high_act=DEF_HIGH, pending discarded
  - o_clk=0, o_tick=0, cfg_ready=1, cfg_err=0
- Counter compare uses W-bit unsigned arithmetic. div_act-1 and div_act-high_act never underflow, because legality is enforced.

## Timing
- Latency from en rising (sampled at edge E) to first o_tick: high in the cycle after E.
- Default settings: o_clk is 50 cycles low then 50 high, with period 100. o_tick fires every 100 cycles, coincident with the first low cycle.
- Config accepted at edge T, not on a wrap: cfg_ready=0 from T+1 up to and including the cycle of the last old-period count. It is 1 again in the first cycle of the new period.
- cfg_err is asserted exactly one cycle, the cycle after the offending transfer edge.
- cfg_valid while cfg_ready=0: ignored. No error, no overwrite of the pending slot.
- Odd period (e.g. div=5, high=2): 3 low + 2 high, no duty rounding beyond that.
- Minimum period div=2, high=1: o_clk toggles every cycle and o_tick fires every 2 cycles.

## Test plan
- Reset, en=1, defaults -> first o_tick the cycle after en. Period 100, o_clk 50 low / 50 high, ten periods with no drift.
- Running defaults, at cnt=20 send div=10, high=3 -> cfg_ready=0 until wrap. Old period completes at 100 cycles. Next period is 7 low / 3 high, with o_tick at its start.
- Config exactly on the wrap edge (cnt=99) with div=4, high=2 -> the immediately following period is 2 low / 2 high, and cfg_ready never drops.
- Illegal configs div=1, high=0, and high=div=8 -> each gives a one-cycle cfg_err, cfg_ready stays 1, and output period is unchanged at 100.
- en low mid-period at cnt=30 -> next cycle o_clk=0, o_tick=0, frozen. Config div=6, high=1 while idle applies at once. On en high, the pattern is 5 low / 1 high with a leading tick.
- Pending config present, reset pulsed at cnt=60 -> after reset the defaults are active (100/50), pending is lost, and cfg_ready=1.
